// File: rtl/coeff_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coeff_bank_if                                                   |
// | Purpose  : Bundles the coefficient-bank signals: fetch-stage handshake,    |
// |            internal coefficient RAM read port, frame swap strobe and the   |
// |            datapath random-access read port.                               |
// | Ports    : coeff_ready, ram_re, ram_addr, ram_data, frame_start, idx,      |
// |            coeff_out, bank_valid, load_busy, swap_done                     |
// |            master : drives the bank (fetch stage / RAM / datapath side)    |
// |            slave  : the coefficient bank itself                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface coeff_bank_if #(
  parameter int COEFF_ADDR_SIZE = 5,
  parameter int DATA_SIZE       = 32
) ();
  logic                       coeff_ready;
  logic                       ram_re;
  logic [COEFF_ADDR_SIZE-1:0] ram_addr;
  logic [DATA_SIZE-1:0]       ram_data;
  logic                       frame_start;
  logic [COEFF_ADDR_SIZE-1:0] idx;
  logic [DATA_SIZE-1:0]       coeff_out;
  logic                       bank_valid;
  logic                       load_busy;
  logic                       swap_done;

  modport master (
    output coeff_ready, ram_data, frame_start, idx,
    input  ram_re, ram_addr, coeff_out, bank_valid, load_busy, swap_done
  );

  modport slave (
    input  coeff_ready, ram_data, frame_start, idx,
    output ram_re, ram_addr, coeff_out, bank_valid, load_busy, swap_done
  );
endinterface
`default_nettype wire

// File: rtl/coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coeff_bank                                                      |
// | Purpose  : Double-buffered coefficient store. On a coeff_ready rising edge |
// |            the full coefficient set is streamed from the fetch stage's     |
// |            internal RAM into the shadow bank; at the next frame_start the  |
// |            shadow becomes the active bank. The active bank answers         |
// |            registered random-access reads so coefficients never change     |
// |            mid-frame.                                                      |
// | Ports    : clk   - system clock                                            |
// |            nRST  - asynchronous reset, active high                         |
// |            bus   - coeff_bank_if.slave (handshake, RAM port, read port)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module coeff_bank #(
  parameter int COEFF_ADDR_SIZE = 5,
  parameter int COEFF_NB        = 26,
  parameter int DATA_SIZE       = 32
) (
  input  wire logic   clk,
  input  wire logic   nRST,
  coeff_bank_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_PEND = 2'd2;

  localparam logic [COEFF_ADDR_SIZE:0]   c_NB   = (COEFF_ADDR_SIZE+1)'(COEFF_NB);
  localparam logic [COEFF_ADDR_SIZE-1:0] c_LAST = COEFF_ADDR_SIZE'(COEFF_NB - 1);

  logic [1:0]                 state_q, state_d;
  logic                       cr_prev_q;
  logic [COEFF_ADDR_SIZE-1:0] rd_cnt_q;
  logic [COEFF_ADDR_SIZE-1:0] wr_cnt_q;
  logic                       issue_done_q;
  logic                       re_dly_q;
  logic                       act_sel_q;
  logic                       bank_valid_q;
  logic [DATA_SIZE-1:0]       coeff_out_q;

  // Bank contents carry no reset; index act_sel_q is active, ~act_sel_q is shadow.
  logic [DATA_SIZE-1:0]       bank_q [2][COEFF_NB];

  logic                       w_rise;
  logic                       w_swap;
  logic                       w_load_start;
  logic                       w_wr_en;
  logic                       w_ram_re;
  logic                       w_load_busy;
  logic                       w_swap_done;
  logic [DATA_SIZE-1:0]       w_rd_word;

  assign w_rise = bus.coeff_ready & ~cr_prev_q;
  assign w_swap = (state_q == c_PEND) && bus.frame_start;
  // In PENDING a simultaneous frame_start wins and the edge is dropped.
  assign w_load_start = w_rise &&
                        ((state_q == c_IDLE) || ((state_q == c_PEND) && !bus.frame_start));
  // RAM data returns one cycle after each issued read.
  assign w_wr_en = (state_q == c_LOAD) && re_dly_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (w_load_start) state_d = c_LOAD;
      c_LOAD: if (w_wr_en && (wr_cnt_q == c_LAST)) state_d = c_PEND;
      c_PEND: begin
        if (w_swap)            state_d = c_IDLE;
        else if (w_load_start) state_d = c_LOAD;
      end
      default:                 state_d = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_ram_re    = 1'b0;
    w_load_busy = 1'b0;
    w_swap_done = 1'b0;
    case (state_q)
      c_LOAD: begin
        w_ram_re    = ~issue_done_q;
        w_load_busy = 1'b1;
      end
      c_PEND:  w_swap_done = bus.frame_start;
      default: ;
    endcase
  end

  // ---------------- Counters, bank select, read port ----------------
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      cr_prev_q    <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      issue_done_q <= 1'b0;
      re_dly_q     <= 1'b0;
      act_sel_q    <= 1'b0;
      bank_valid_q <= 1'b0;
      coeff_out_q  <= '0;
    end else begin
      cr_prev_q <= bus.coeff_ready;
      re_dly_q  <= w_ram_re;
      if (w_load_start) begin
        rd_cnt_q     <= '0;
        wr_cnt_q     <= '0;
        issue_done_q <= 1'b0;
      end else begin
        // rd_cnt_q parks on the last address so ram_addr holds it afterwards.
        if (w_ram_re) begin
          if (rd_cnt_q == c_LAST) issue_done_q <= 1'b1;
          else                    rd_cnt_q     <= rd_cnt_q + 1'b1;
        end
        if (w_wr_en) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      if (w_swap) begin
        act_sel_q    <= ~act_sel_q;
        bank_valid_q <= 1'b1;
      end
      // Uses the pre-swap act_sel_q, so the swap cycle still reads the old bank.
      coeff_out_q <= w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) bank_q[~act_sel_q][wr_cnt_q] <= bus.ram_data;
  end

  always_comb begin
    w_rd_word = '0;
    if (bank_valid_q && ({1'b0, bus.idx} < c_NB)) w_rd_word = bank_q[act_sel_q][bus.idx];
  end

  assign bus.ram_re     = w_ram_re;
  assign bus.ram_addr   = rd_cnt_q;
  assign bus.coeff_out  = coeff_out_q;
  assign bus.bank_valid = bank_valid_q;
  assign bus.load_busy  = w_load_busy;
  assign bus.swap_done  = w_swap_done;

endmodule
`default_nettype wire
